// File: rtl/uart_string_streamer.sv
// uart_string_streamer
// Streams a null-terminated string, packed two characters per 16-bit ROM word
// (low byte first), from the program ROM into the UART transmitter. It runs the
// atx_busy/atx_load handshake for each character so the CPU does not have to.

module uart_string_streamer #(
    parameter int LOAD_MIN_CYCLES = 4,   // minimum cycles atx_load stays high per character
    parameter int MAX_CHARS       = 255  // characters per transfer before overrun
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_start_addr,
    input  logic        i_abort,
    output logic [15:0] o_rom_addr,
    input  logic [15:0] i_rom_data,
    input  logic        i_atx_busy,
    output logic [7:0]  o_atx_data,
    output logic        o_atx_load,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun,
    output logic [7:0]  o_char_count
);

    // Load counter is wide enough to hold LOAD_MIN_CYCLES-1 and saturates, so a
    // UART that never raises busy cannot make it wrap back below the threshold.
    localparam int                CNT_W     = $clog2(LOAD_MIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  LOAD_THR  = CNT_W'(LOAD_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [7:0]        MAX_COUNT = 8'(MAX_CHARS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEL,
        ST_WAIT_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_rom_addr,   w_rom_addr_nxt;
    logic [15:0]      r_word,       w_word_nxt;
    logic             r_half,       w_half_nxt;
    logic [7:0]       r_char_count, w_char_count_nxt;
    logic             r_overrun,    w_overrun_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_done,       w_done_nxt;
    logic [7:0]       r_atx_data,   w_atx_data_nxt;
    logic             r_atx_load,   w_atx_load_nxt;
    logic [CNT_W-1:0] r_load_cnt,   w_load_cnt_nxt;

    // Character currently selected from the latched word.
    logic [7:0]       w_byte;
    assign w_byte = r_half ? r_word[15:8] : r_word[7:0];

    // State register; reset forces IDLE on the same edge from any state.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the whole sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_rom_addr_nxt   = r_rom_addr;
        w_word_nxt       = r_word;
        w_half_nxt       = r_half;
        w_char_count_nxt = r_char_count;
        w_overrun_nxt    = r_overrun;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_atx_data_nxt   = r_atx_data;
        w_atx_load_nxt   = r_atx_load;
        w_load_cnt_nxt   = r_load_cnt;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_rom_addr_nxt   = i_start_addr;
                    w_half_nxt       = 1'b0;
                    w_char_count_nxt = 8'd0;
                    w_overrun_nxt    = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = ST_READ;
                end
            end

            // rom_addr has been stable for a full cycle, so the ROM output is valid.
            ST_READ: begin
                w_word_nxt  = i_rom_data;
                w_state_nxt = ST_SEL;
            end

            // Character boundary: terminator and abort take priority over overrun.
            ST_SEL: begin
                if (w_byte == 8'h00 || i_abort) begin
                    w_state_nxt = ST_FINISH;
                end else if (r_char_count == MAX_COUNT) begin
                    w_overrun_nxt = 1'b1;
                    w_state_nxt   = ST_FINISH;
                end else begin
                    w_atx_data_nxt = w_byte;
                    w_state_nxt    = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (!i_atx_busy) begin
                    w_atx_load_nxt = 1'b1;
                    w_load_cnt_nxt = '0;
                    w_state_nxt    = ST_LOAD;
                end
            end

            // Hold the strobe for the minimum width and until the UART shows it has
            // taken the byte. abort is deliberately not looked at here.
            ST_LOAD: begin
                if (r_load_cnt != CNT_MAX) begin
                    w_load_cnt_nxt = r_load_cnt + 1'b1;
                end
                if (r_load_cnt >= LOAD_THR && i_atx_busy) begin
                    w_atx_load_nxt = 1'b0;
                    w_state_nxt    = ST_RELEASE;
                end
            end

            // Low half done: reuse the latched word. High half done: fetch the next.
            ST_RELEASE: begin
                w_char_count_nxt = r_char_count + 8'd1;
                if (!r_half) begin
                    w_half_nxt  = 1'b1;
                    w_state_nxt = ST_SEL;
                end else begin
                    w_half_nxt     = 1'b0;
                    w_rom_addr_nxt = r_rom_addr + 16'd1;
                    w_state_nxt    = ST_READ;
                end
            end

            ST_FINISH: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; all return to their idle values on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr   <= 16'd0;
            r_word       <= 16'd0;
            r_half       <= 1'b0;
            r_char_count <= 8'd0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_atx_data   <= 8'd0;
            r_atx_load   <= 1'b0;
            r_load_cnt   <= '0;
        end else begin
            r_rom_addr   <= w_rom_addr_nxt;
            r_word       <= w_word_nxt;
            r_half       <= w_half_nxt;
            r_char_count <= w_char_count_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_atx_data   <= w_atx_data_nxt;
            r_atx_load   <= w_atx_load_nxt;
            r_load_cnt   <= w_load_cnt_nxt;
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_atx_data   = r_atx_data;
    assign o_atx_load   = r_atx_load;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overrun    = r_overrun;
    assign o_char_count = r_char_count;

endmodule
